// File: rtl/buff_fifo_if.sv
// ----------------------------------------------------------------------------
// dti: valid/ready streaming interface.
//
// Transfer happens on a rising clock edge when valid and ready are both high.
// Once valid is raised the producer keeps data stable and valid high until the
// transfer completes.
//
// Signals:
//   data   [W-1:0]  payload, driven by the producer
//   valid           payload present, driven by the producer
//   ready           sink can accept, driven by the consumer
//
// Modports:
//   producer / master : drives data and valid, observes ready
//   consumer / slave  : observes data and valid, drives ready
// ----------------------------------------------------------------------------
interface dti #(
    parameter int W = 16
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input  ready);
    modport consumer (input  data, input  valid, output ready);

    // Aliases for code that names the ends by bus role.
    modport master   (output data, output valid, input  ready);
    modport slave    (input  data, input  valid, output ready);
endinterface : dti

// File: rtl/buff_fifo.sv
// ----------------------------------------------------------------------------
// buff_fifo: DEPTH-entry circular buffer between two dti streams.
//
// Decouples a producer from a consumer and sustains one transfer per cycle
// when DEPTH >= 2. With FALLTHROUGH=1 an empty buffer passes the input word
// straight to the output in the same cycle. din.ready depends only on
// registered occupancy, so there is no combinational path from dout.ready to
// din.ready.
//
// Parameters:
//   DEPTH        number of storage entries (>= 1, any value)
//   FALLTHROUGH  0: registered output, 1: zero-latency bypass when empty
//
// Ports:
//   clk    clock
//   rst    synchronous, active-high reset
//   din    dti consumer end (input stream)
//   dout   dti producer end (output stream)
//   level  number of stored entries, registered
// ----------------------------------------------------------------------------
module buff_fifo #(
    parameter int DEPTH       = 2,
    parameter bit FALLTHROUGH = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    dti.consumer                       din,
    dti.producer                       dout,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int W_IN  = $bits(din.data);
    localparam int W_OUT = $bits(dout.data);
    localparam int W     = W_IN;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    if (W_IN != W_OUT) begin : g_width_check
        $error("buff_fifo: din data width %0d differs from dout data width %0d",
               W_IN, W_OUT);
    end

    if (DEPTH < 1) begin : g_depth_check
        $error("buff_fifo: DEPTH must be at least 1, got %0d", DEPTH);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q,  count_d;

    // Handshake and control
    logic         empty;
    logic         full;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         push;
    logic         pop;
    logic         bypass;
    logic         wr_en;
    logic         rd_en;

    // Wraps exactly at DEPTH-1, so non-power-of-two depths need no spare slot.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        out_valid = 1'b0;
        out_data  = mem_q[rd_ptr_q];

        empty    = (count_q == '0);
        full     = (count_q == FULL_COUNT);
        // A full buffer refuses a push even when a pop frees a slot this
        // cycle; keeps din.ready free of any dout.ready dependency.
        in_ready = !rst && !full;

        if (FALLTHROUGH) begin
            out_valid = !rst && (!empty || din.valid);
            out_data  = empty ? din.data : mem_q[rd_ptr_q];
        end else begin
            out_valid = !rst && !empty;
        end
    end

    assign din.ready  = in_ready;
    assign dout.valid = out_valid;
    assign dout.data  = out_data;
    assign level      = count_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        push   = din.valid && in_ready;
        pop    = out_valid && dout.ready;
        // Bypassed word goes straight through: storage and pointers untouched.
        bypass = FALLTHROUGH && empty && push && pop;
        wr_en  = push && !bypass;
        rd_en  = pop  && !bypass;

        wr_ptr_d = wr_en ? advance(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_en ? advance(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates what is visible,
    // and leaving the array reset-free lets it map onto RAM or plain flops.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= din.data;
        end
    end

endmodule : buff_fifo

// File: tb/tb_buff_fifo.sv
// ----------------------------------------------------------------------------
// tb_buff_fifo: scoreboard bench for buff_fifo.
//
// Three instances cover the configurations of interest:
//   u_a  DEPTH=4 FALLTHROUGH=0 W=16  fill/full/drain and mid-stream reset
//   u_b  DEPTH=3 FALLTHROUGH=0 W=8   continuous stream, pointer wrap
//   u_c  DEPTH=2 FALLTHROUGH=1 W=16  empty-buffer bypass
// Stimulus pushes the expected words into per-instance queues; a monitor per
// instance pops and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_buff_fifo;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int b_rx  = 0;

    logic [15:0] qa [$];
    logic [7:0]  qb [$];
    logic [15:0] qc [$];

    dti #(.W(16)) a_in  ();
    dti #(.W(16)) a_out ();
    dti #(.W(8))  b_in  ();
    dti #(.W(8))  b_out ();
    dti #(.W(16)) c_in  ();
    dti #(.W(16)) c_out ();

    logic [2:0] a_level;
    logic [1:0] b_level;
    logic [1:0] c_level;

    buff_fifo #(.DEPTH(4), .FALLTHROUGH(1'b0)) u_a (
        .clk   (clk),
        .rst   (rst_a),
        .din   (a_in.consumer),
        .dout  (a_out.producer),
        .level (a_level)
    );

    buff_fifo #(.DEPTH(3), .FALLTHROUGH(1'b0)) u_b (
        .clk   (clk),
        .rst   (rst_b),
        .din   (b_in.consumer),
        .dout  (b_out.producer),
        .level (b_level)
    );

    buff_fifo #(.DEPTH(2), .FALLTHROUGH(1'b1)) u_c (
        .clk   (clk),
        .rst   (rst_c),
        .din   (c_in.consumer),
        .dout  (c_out.producer),
        .level (c_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Output monitors
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_a && a_out.valid === 1'b1 && a_out.ready === 1'b1) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_out unexpected word: got %0h, expected none", a_out.data);
            end else begin
                check("a_out data", 32'(a_out.data), 32'(qa.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && b_out.valid === 1'b1 && b_out.ready === 1'b1) begin
            b_rx++;
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_out unexpected word: got %0h, expected none", b_out.data);
            end else begin
                check("b_out data", 32'(b_out.data), 32'(qb.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_c && c_out.valid === 1'b1 && c_out.ready === 1'b1) begin
            if (qc.size() == 0) begin
                total++;
                bad++;
                $display("FAIL c_out unexpected word: got %0h, expected none", c_out.data);
            end else begin
                check("c_out data", 32'(c_out.data), 32'(qc.pop_front()));
            end
        end
    end

    // Hard stop if the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
        c_in.valid = 1'b0; c_in.data = '0; c_out.ready = 1'b0;

        // Reset: handshakes forced low while rst is high, even with din.valid.
        tick();
        a_in.valid = 1'b1;
        c_in.valid = 1'b1;
        c_out.ready = 1'b1;
        sample();
        check("rst a din.ready",  32'(a_in.ready),  0);
        check("rst a dout.valid", 32'(a_out.valid), 0);
        check("rst c dout.valid", 32'(c_out.valid), 0);
        tick();
        a_in.valid = 1'b0; c_in.valid = 1'b0; c_out.ready = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        sample();
        check("post-rst a level",      32'(a_level),     0);
        check("post-rst a dout.valid", 32'(a_out.valid), 0);
        check("post-rst a din.ready",  32'(a_in.ready),  1);

        // --- A: fill four words with dout.ready low -----------------------
        tick();
        a_out.ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a_in.valid = 1'b1;
            a_in.data  = 16'(i);
            qa.push_back(16'(i));
            sample();
            check("fill a level",     32'(a_level),    32'(i - 1));
            check("fill a din.ready", 32'(a_in.ready), 1);
            tick();
        end
        a_in.data = 16'h0005;
        qa.push_back(16'h0005);
        sample();
        check("full a din.ready",  32'(a_in.ready),  0);
        check("full a level",      32'(a_level),     4);
        check("full a dout.valid", 32'(a_out.valid), 1);
        check("full a dout.data",  32'(a_out.data),  32'h0001);
        tick();
        sample();
        check("held a level",     32'(a_level),    4);
        check("held a din.ready", 32'(a_in.ready), 0);

        // --- A: drain; full cycle refuses the push, next cycle takes it ---
        tick();
        a_out.ready = 1'b1;
        sample();
        check("drain a level c0",     32'(a_level),    4);
        check("drain a din.ready c0", 32'(a_in.ready), 0);
        tick();
        sample();
        check("drain a level c1",     32'(a_level),    3);
        check("drain a din.ready c1", 32'(a_in.ready), 1);
        tick();
        a_in.valid = 1'b0;
        sample();
        check("drain a level c2", 32'(a_level), 3);
        tick();
        sample();
        check("drain a level c3", 32'(a_level), 2);
        tick();
        sample();
        check("drain a level c4", 32'(a_level), 1);
        tick();
        sample();
        check("drain a level c5",      32'(a_level),     0);
        check("drain a dout.valid c5", 32'(a_out.valid), 0);
        check("drain a queue empty",   32'(qa.size()),   0);

        // --- A: reset mid-drain discards stored words ---------------------
        tick();
        a_out.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in.valid = 1'b1;
            a_in.data  = 16'h0011 * 16'(i + 1);
            qa.push_back(16'h0011 * 16'(i + 1));
            tick();
        end
        a_in.valid  = 1'b0;
        a_out.ready = 1'b1;     // 0x0011 leaves this cycle
        tick();
        a_out.ready = 1'b0;
        tick();
        a_out.ready = 1'b1;
        rst_a = 1'b1;
        sample();
        check("mid-rst a dout.valid", 32'(a_out.valid), 0);
        check("mid-rst a din.ready",  32'(a_in.ready),  0);
        check("mid-rst a queued",     32'(qa.size()),   2);
        qa.delete();            // 0x0022 and 0x0033 must never appear
        tick();
        rst_a = 1'b0;
        sample();
        check("after-rst a level",      32'(a_level),     0);
        check("after-rst a dout.valid", 32'(a_out.valid), 0);
        check("after-rst a din.ready",  32'(a_in.ready),  1);
        repeat (4) tick();
        a_in.valid = 1'b1;
        a_in.data  = 16'h0044;
        qa.push_back(16'h0044);
        tick();
        a_in.valid = 1'b0;
        repeat (3) tick();
        sample();
        check("after-rst a queue empty", 32'(qa.size()), 0);
        check("after-rst a level end",   32'(a_level),   0);

        // --- B: continuous stream through DEPTH=3 -------------------------
        tick();
        b_in.valid  = 1'b1;
        b_out.ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            b_in.data = 8'(i);
            qb.push_back(8'(i));
            sample();
            if (i == 0) begin
                check("stream b dout.valid first", 32'(b_out.valid), 0);
                check("stream b level first",      32'(b_level),     0);
            end else begin
                check("stream b level", 32'(b_level), 1);
            end
            tick();
        end
        b_in.valid = 1'b0;
        sample();
        check("stream b level tail", 32'(b_level), 1);
        tick();
        sample();
        check("stream b level end",   32'(b_level),   0);
        check("stream b words seen",  32'(b_rx),      100);
        check("stream b queue empty", 32'(qb.size()), 0);

        // --- C: fall-through bypass ---------------------------------------
        tick();
        c_out.ready = 1'b1;
        c_in.valid  = 1'b1;
        c_in.data   = 16'hBEEF;
        qc.push_back(16'hBEEF);
        sample();
        check("bypass c dout.valid", 32'(c_out.valid), 1);
        check("bypass c dout.data",  32'(c_out.data),  32'hBEEF);
        check("bypass c level",      32'(c_level),     0);
        tick();
        c_in.valid = 1'b0;
        sample();
        check("bypass c level after",      32'(c_level),     0);
        check("bypass c dout.valid after", 32'(c_out.valid), 0);

        // Stalled output: word shown at once, then held from storage.
        tick();
        c_out.ready = 1'b0;
        c_in.valid  = 1'b1;
        c_in.data   = 16'hCAFE;
        qc.push_back(16'hCAFE);
        sample();
        check("stall c dout.valid", 32'(c_out.valid), 1);
        check("stall c dout.data",  32'(c_out.data),  32'hCAFE);
        tick();
        c_in.valid = 1'b0;
        sample();
        check("stall c level",           32'(c_level),     1);
        check("stall c dout.data held",  32'(c_out.data),  32'hCAFE);
        check("stall c dout.valid held", 32'(c_out.valid), 1);
        tick();
        c_out.ready = 1'b1;
        tick();
        sample();
        check("stall c level end",   32'(c_level),   0);
        check("stall c queue empty", 32'(qc.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_buff_fifo
